// File: rtl/u409_ata_pio_sm_pkg.sv
// u409_ata_pio_sm_pkg
//   Shared U409 definitions for the ATA PIO cycle engine. This package holds
//   the state encoding, the PIO0/PIO4 timing constants in CLK40 cycles, and
//   the IORDY stretch limit.
//   There are no ports. Import it with u409_ata_pio_sm_pkg::*.
package u409_ata_pio_sm_pkg;

  typedef logic [2:0] state_t;

  // The state encodings are plain constants so that older logic can compare against them.
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETUP   = 3'd1;
  localparam state_t ST_STROBE  = 3'd2;
  localparam state_t ST_HOLD    = 3'd3;
  localparam state_t ST_RECOVER = 3'd4;

  // PIO0 timings: 70 ns setup, 165 ns strobe, 600 ns cycle.
  localparam int PIO0_T1 = 3;
  localparam int PIO0_T2 = 7;
  localparam int PIO0_T0 = 24;

  // PIO4 timings: 25 ns setup, 70 ns strobe, 120 ns cycle.
  localparam int PIO4_T1 = 1;
  localparam int PIO4_T2 = 3;
  localparam int PIO4_T0 = 5;

  // The longest IORDY stretch allowed, in cycles (1250 ns).
  localparam int IORDY_MAX_CYC = 50;

endpackage

// File: rtl/u409_ata_pio_sm_if.sv
// u409_ata_pio_sm_if
//   Bus bundle between the CPU-side decode, the ATA drive pins and the PIO
//   cycle engine.
//   Signals:
//     TSn, RnW, ATA_SPACE, SEC_SEL : qualified transfer start and its attributes
//     PPIO, SPIO                   : per-channel mode select (1 = PIO4, 0 = PIO0)
//     IORDY                        : raw device-ready input from the drive
//     ATA_IORn, ATA_IOWn           : active-low device strobes
//     ATA_TACK, ATA_TIMEOUT        : one-cycle completion and stretch-abort pulses
//   Modports:
//     master : the side that drives start and mode and sees the results
//     slave  : the cycle engine itself
interface u409_ata_pio_sm_if;
  logic TSn;
  logic RnW;
  logic ATA_SPACE;
  logic SEC_SEL;
  logic PPIO;
  logic SPIO;
  logic IORDY;
  logic ATA_IORn;
  logic ATA_IOWn;
  logic ATA_TACK;
  logic ATA_TIMEOUT;

  modport master (
    output TSn, RnW, ATA_SPACE, SEC_SEL, PPIO, SPIO, IORDY,
    input  ATA_IORn, ATA_IOWn, ATA_TACK, ATA_TIMEOUT
  );

  modport slave (
    input  TSn, RnW, ATA_SPACE, SEC_SEL, PPIO, SPIO, IORDY,
    output ATA_IORn, ATA_IOWn, ATA_TACK, ATA_TIMEOUT
  );
endinterface

// File: rtl/u409_ata_pio_sm_sync2.sv
// u409_sync2
//   Two-flop synchroniser for a slow asynchronous ready line such as IORDY
//   or FLASH_RDY. It clears to 0, which means "not ready", while in reset.
//   Ports:
//     clk   : sampling clock
//     rst_n : synchronous active-low reset
//     d     : asynchronous input
//     q     : synchronised output, two clocks of latency
module u409_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/u409_ata_pio_sm.sv
// u409_ata_pio_sm
//   Timing engine for ATA PIO cycles. A qualified start runs through these
//   states:
//     SETUP (T1) -> STROBE (T2, stretched by IORDY) -> HOLD (1) -> RECOVER (until CYC >= T0)
//   The per-channel PIO mode is latched when the cycle starts.
//   ATA_TACK pulses in the final strobe cycle, while read data is still driven.
//   Ports:
//     CLK40  : 40 MHz clock
//     RESETn : synchronous active-low reset
//     bus    : u409_ata_pio_sm_if slave modport (start, mode, IORDY, strobes, TACK)
module u409_ata_pio_sm
  import u409_ata_pio_sm_pkg::*;
#(
  parameter int SLOW_T1   = PIO0_T1,
  parameter int SLOW_T2   = PIO0_T2,
  parameter int SLOW_T0   = PIO0_T0,
  parameter int FAST_T1   = PIO4_T1,
  parameter int FAST_T2   = PIO4_T2,
  parameter int FAST_T0   = PIO4_T0,
  parameter int IORDY_MAX = IORDY_MAX_CYC
) (
  input logic               CLK40,
  input logic               RESETn,
  u409_ata_pio_sm_if.slave  bus
);

  localparam logic [5:0] S_T1    = 6'(SLOW_T1);
  localparam logic [5:0] S_T2    = 6'(SLOW_T2);
  localparam logic [5:0] S_T0    = 6'(SLOW_T0);
  localparam logic [5:0] F_T1    = 6'(FAST_T1);
  localparam logic [5:0] F_T2    = 6'(FAST_T2);
  localparam logic [5:0] F_T0    = 6'(FAST_T0);
  localparam logic [5:0] STR_MAX = 6'(IORDY_MAX);
  localparam logic [5:0] SAT     = 6'd63;

  state_t     state, next_state;
  logic [5:0] cyc, cnt, stretch;
  logic [5:0] t1, t2, t0;
  logic       dir;
  logic       pend, pend_dir, pend_mode;
  logic       ior_n, iow_n;
  logic       iordy_s;

  logic       start, start_mode;
  logic       load_new, load_pend;
  logic       sel_mode, sel_dir;
  logic       at_width, ready_end, forced, final_cyc;

  u409_sync2 iordy_sync (
    .clk   (CLK40),
    .rst_n (RESETn),
    .d     (bus.IORDY),
    .q     (iordy_s)
  );

  assign start      = !bus.TSn && bus.ATA_SPACE;
  assign start_mode = bus.SEC_SEL ? bus.SPIO : bus.PPIO;

  // When IORDY comes back in the same cycle that the limit is reached, the
  // cycle ends normally. Only a forced end raises TIMEOUT.
  assign at_width  = (cnt >= t2);
  assign ready_end = at_width && iordy_s;
  assign forced    = (stretch >= STR_MAX);
  assign final_cyc = (state == ST_STROBE) && (ready_end || forced);

  assign bus.ATA_TACK    = final_cyc;
  assign bus.ATA_TIMEOUT = (state == ST_STROBE) && forced && !ready_end;
  assign bus.ATA_IORn    = ior_n;
  assign bus.ATA_IOWn    = iow_n;

  // Next-state logic. When a cycle starts, the attributes come either from the
  // live inputs or from the pending start that was captured in HOLD/RECOVER.
  // A start that arrives on the same edge that RECOVER finishes is used directly.
  always_comb begin
    next_state = state;
    load_new   = 1'b0;
    load_pend  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_SETUP;
          load_new   = 1'b1;
        end
      end
      ST_SETUP:  if (cnt >= t1) next_state = ST_STROBE;
      ST_STROBE: if (final_cyc) next_state = ST_HOLD;
      ST_HOLD:   next_state = ST_RECOVER;
      ST_RECOVER: begin
        if (cyc >= t0) begin
          if (pend) begin
            next_state = ST_SETUP;
            load_pend  = 1'b1;
          end else if (start) begin
            next_state = ST_SETUP;
            load_new   = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    sel_mode = load_new ? start_mode : pend_mode;
    sel_dir  = load_new ? bus.RnW    : pend_dir;
  end

  // State, counters, latched attributes and registered strobes. The strobes
  // are decoded from the next state, so they change on the same edge as the
  // state and never glitch.
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      state     <= ST_IDLE;
      cyc       <= '0;
      cnt       <= '0;
      stretch   <= '0;
      t1        <= '0;
      t2        <= '0;
      t0        <= '0;
      dir       <= 1'b0;
      pend      <= 1'b0;
      pend_dir  <= 1'b0;
      pend_mode <= 1'b0;
      ior_n     <= 1'b1;
      iow_n     <= 1'b1;
    end else begin
      state <= next_state;

      if (load_new || load_pend) begin
        cyc <= 6'd1;
      end else if (state != ST_IDLE && cyc != SAT) begin
        cyc <= cyc + 6'd1;
      end

      if (next_state != state) begin
        cnt <= 6'd1;
      end else if (cnt != SAT) begin
        cnt <= cnt + 6'd1;
      end

      if (state == ST_STROBE && !final_cyc) begin
        if (at_width) stretch <= stretch + 6'd1;
      end else begin
        stretch <= '0;
      end

      if (load_new || load_pend) begin
        dir <= sel_dir;
        t1  <= sel_mode ? F_T1 : S_T1;
        t2  <= sel_mode ? F_T2 : S_T2;
        t0  <= sel_mode ? F_T0 : S_T0;
      end

      if (load_new || load_pend) begin
        pend <= 1'b0;
      end else if ((state == ST_HOLD || state == ST_RECOVER) && start) begin
        pend      <= 1'b1;
        pend_dir  <= bus.RnW;
        pend_mode <= start_mode;
      end

      ior_n <= !(next_state == ST_STROBE && dir);
      iow_n <= !(next_state == ST_STROBE && !dir);
    end
  end

endmodule

// File: tb/tb_u409_ata_pio_sm.sv
// tb_u409_ata_pio_sm
//   Directed bench for the ATA PIO cycle engine. Each start pushes the
//   expected TACK edge, strobe length, direction and timeout. These are worked
//   out from the PIO timing rules. A negedge monitor pops an entry at every
//   TACK and compares it with the DUT.
//   Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_u409_ata_pio_sm;

  localparam int STRETCH_LIMIT = 50;
  localparam int NEVER         = 1000000;

  typedef struct {
    int   tack_edge;
    int   len;
    logic rd;
    logic tmo;
  } exp_t;

  logic clk40 = 1'b0;
  logic resetn;
  int   edge_no = 0;
  int   total = 0;
  int   bad = 0;
  int   run_len = 0;
  bit   mon_on = 1'b0;
  exp_t exp_q[$];

  u409_ata_pio_sm_if bus ();

  u409_ata_pio_sm dut (
    .CLK40  (clk40),
    .RESETn (resetn),
    .bus    (bus)
  );

  // 40 MHz clock, plus an edge count that the expected TACK times refer to.
  always #12.5 clk40 = ~clk40;
  always @(posedge clk40) edge_no <= edge_no + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic goto_edge(input int n);
    while (edge_no < n) begin
      @(posedge clk40);
      #1;
    end
  endtask

  // Drive a one-cycle start. The DUT samples it on the returned edge.
  task automatic apply_stimulus(input logic rnw, input logic sec, output int s);
    bus.TSn       = 1'b0;
    bus.ATA_SPACE = 1'b1;
    bus.RnW       = rnw;
    bus.SEC_SEL   = sec;
    s = edge_no + 1;
    goto_edge(s);
    bus.TSn       = 1'b1;
    bus.ATA_SPACE = 1'b0;
  endtask

  // setup_edge is the edge after which the first SETUP cycle runs.
  // hi_from is the first edge after which the synchronised IORDY reads 1.
  task automatic push_expected(input int setup_edge, input int t1, input int t2,
                               input int hi_from, input logic rd);
    exp_t e;
    int   m;
    m = setup_edge + t1 + t2 - 1;
    if (hi_from > m) m = hi_from;
    e.len = m - (setup_edge + t1) + 1;
    e.tmo = 1'b0;
    if (e.len > t2 + STRETCH_LIMIT) begin
      e.len = t2 + STRETCH_LIMIT;
      e.tmo = 1'b1;
    end
    e.tack_edge = setup_edge + t1 + e.len - 1;
    e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk40);
      #1;
      k++;
    end
    check_output("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: strobe exclusivity and strobe length, plus a scoreboard pop on every TACK.
  always @(negedge clk40) begin
    exp_t e;
    if (mon_on) begin
      if (bus.ATA_IORn !== 1'b1 || bus.ATA_IOWn !== 1'b1) begin
        run_len++;
        check_output("strobe_excl", 32'(bus.ATA_IORn | bus.ATA_IOWn), 32'd1);
      end else begin
        run_len = 0;
      end
      if (bus.ATA_TACK !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check_output("tack_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_output("tack_edge", 32'(edge_no), 32'(e.tack_edge));
          check_output("strobe_len", 32'(run_len), 32'(e.len));
          check_output("tack_ior", 32'(bus.ATA_IORn), 32'(!e.rd));
          check_output("tack_iow", 32'(bus.ATA_IOWn), 32'(e.rd));
          check_output("tack_timeout", 32'(bus.ATA_TIMEOUT), 32'(e.tmo));
        end
      end else if (bus.ATA_TIMEOUT !== 1'b0) begin
        check_output("timeout_stray", 32'(bus.ATA_TIMEOUT), 32'd0);
      end
    end
  end

  initial begin
    #200us;
    $display("[TB] FAIL watchdog expired at edge %0d", edge_no);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s, s2, dummy;
    bus.TSn = 1'b1; bus.ATA_SPACE = 1'b0; bus.RnW = 1'b1; bus.SEC_SEL = 1'b0;
    bus.PPIO = 1'b1; bus.SPIO = 1'b1; bus.IORDY = 1'b1;
    resetn = 1'b0;

    // Reset state
    goto_edge(3);
    check_output("rst_iorn", 32'(bus.ATA_IORn), 32'd1);
    check_output("rst_iown", 32'(bus.ATA_IOWn), 32'd1);
    check_output("rst_tack", 32'(bus.ATA_TACK), 32'd0);
    check_output("rst_timeout", 32'(bus.ATA_TIMEOUT), 32'd0);
    resetn = 1'b1;
    mon_on = 1'b1;
    goto_edge(edge_no + 2);

    // Primary PIO4 read. A write start in HOLD stays pending until RECOVER
    // ends. PPIO then drops mid-cycle, and the pending PIO4 timing must be kept.
    $display("[TB] primary PIO4 read + pending write");
    bus.PPIO = 1'b1;
    apply_stimulus(1'b1, 1'b0, s);
    push_expected(s, 1, 3, 0, 1'b1);
    goto_edge(s + 4);
    apply_stimulus(1'b0, 1'b0, dummy);
    s2 = s + 6;
    push_expected(s2, 1, 3, 0, 1'b0);
    goto_edge(s2 + 1);
    bus.PPIO = 1'b0;
    drain(40);
    goto_edge(edge_no + 30);

    // Secondary PIO0 write. A start arriving in STROBE must be ignored.
    $display("[TB] secondary PIO0 write");
    bus.PPIO = 1'b1;
    bus.SPIO = 1'b0;
    apply_stimulus(1'b0, 1'b1, s);
    push_expected(s, 3, 7, 0, 1'b0);
    goto_edge(s + 4);
    apply_stimulus(1'b1, 1'b0, dummy);
    drain(40);
    goto_edge(edge_no + 30);

    // PIO4 read with IORDY low for 10 sampled edges, crossing the T2 boundary.
    $display("[TB] IORDY stretch");
    bus.PPIO  = 1'b1;
    bus.SPIO  = 1'b1;
    bus.IORDY = 1'b0;
    apply_stimulus(1'b1, 1'b0, s);
    push_expected(s, 1, 3, s + 9 + 2, 1'b1);
    goto_edge(s + 9);
    bus.IORDY = 1'b1;
    drain(40);
    goto_edge(edge_no + 30);

    // PIO0 read with IORDY stuck low. The forced end pulses TACK and TIMEOUT together.
    $display("[TB] IORDY stuck low");
    bus.PPIO  = 1'b0;
    bus.IORDY = 1'b0;
    apply_stimulus(1'b1, 1'b0, s);
    push_expected(s, 3, 7, NEVER, 1'b1);
    drain(100);
    bus.IORDY = 1'b1;
    goto_edge(edge_no + 30);

    // Back-to-back PIO0. The second start arrives in RECOVER at CYC 12 and
    // its SETUP waits for CYC 24.
    $display("[TB] back-to-back PIO0");
    bus.PPIO = 1'b0;
    apply_stimulus(1'b1, 1'b0, s);
    push_expected(s, 3, 7, 0, 1'b1);
    goto_edge(s + 11);
    apply_stimulus(1'b0, 1'b0, dummy);
    push_expected(s + 24, 3, 7, 0, 1'b0);
    drain(80);
    goto_edge(edge_no + 30);

    // Reset on the third strobe cycle, then a normal PIO4 read.
    $display("[TB] reset mid-strobe");
    bus.PPIO = 1'b0;
    apply_stimulus(1'b1, 1'b0, s);
    goto_edge(s + 5);
    check_output("mid_strobe_iorn", 32'(bus.ATA_IORn), 32'd0);
    resetn = 1'b0;
    goto_edge(s + 6);
    check_output("abort_iorn", 32'(bus.ATA_IORn), 32'd1);
    check_output("abort_iown", 32'(bus.ATA_IOWn), 32'd1);
    check_output("abort_tack", 32'(bus.ATA_TACK), 32'd0);
    resetn = 1'b1;
    goto_edge(s + 12);
    bus.PPIO = 1'b1;
    apply_stimulus(1'b1, 1'b0, s);
    push_expected(s, 1, 3, 0, 1'b1);
    drain(40);
    goto_edge(edge_no + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/u409_ata_pio_sm.md
Name: u409_ata_pio_sm

Overview:
- Cycle-timing state machine for the on-board ATA/IDE PIO ports.
- Sits downstream of the address-decode stage: consumes ATA_SPACE and the qualified transfer start.
- Drives the ATA read/write strobes with the timing of the selected PIO mode.
- Produces ATA_TACK, which the transfer-ack stage merges into TACKn. This is the ATA equivalent of the RTC and flash cycle engines.

Parameters:
- SLOW_T1, 3, address-to-strobe setup in CLK40 cycles, PIO0 (70 ns)
- SLOW_T2, 7, strobe active width in cycles, PIO0 (165 ns)
- SLOW_T0, 24, minimum total cycle time in cycles, PIO0 (600 ns)
- FAST_T1, 1, setup in cycles, PIO4 (25 ns)
- FAST_T2, 3, strobe width in cycles, PIO4 (70 ns)
- FAST_T0, 5, minimum cycle time in cycles, PIO4 (120 ns)
- IORDY_MAX, 50, maximum IORDY stretch in cycles (1250 ns) before forced completion

Ports:
- CLK40  in  1  40 MHz global clock from PLL
- RESETn  in  1  synchronous active-low reset, sampled on CLK40 rising edge
- TSn  in  1  68040 transfer start, active low
- RnW  in  1  1 = read, 0 = write
- ATA_SPACE  in  1  address decode hit on either ATA channel
- SEC_SEL  in  1  0 = primary channel, 1 = secondary channel; decoded from the address, valid with TSn
- PPIO  in  1  primary channel PIO mode: 1 = PIO4, 0 = PIO0
- SPIO  in  1  secondary channel PIO mode: same encoding as PPIO
- IORDY  in  1  device ready, synchronised internally by a 2-flop chain
- ATA_IORn  out  1  device read strobe, active low
- ATA_IOWn  out  1  device write strobe, active low
- ATA_TACK  out  1  one-cycle transfer-ack request to the transfer-ack stage
- ATA_TIMEOUT  out  1  one-cycle pulse: IORDY stretch exceeded IORDY_MAX

Behaviour:
- Reset:
  - State = IDLE.
  - ATA_IORn = 1, ATA_IOWn = 1, ATA_TACK = 0, ATA_TIMEOUT = 0.
  - Pending flag cleared; all counters = 0.
  - Reset taken in any state aborts the cycle immediately; strobes are deasserted on the same edge.
- Start condition: TSn = 0 and ATA_SPACE = 1, sampled on a CLK40 edge. On start, latch:
  - RnW into DIR
  - mode = SEC_SEL ? SPIO : PPIO
  - T1/T2/T0 from the FAST or SLOW parameter set
- Cycle counter: a 6-bit cycle counter CYC counts from the edge after the start and saturates at 63.
- States:
  - IDLE: on start -> SETUP; CYC = 1.
  - SETUP: hold for T1 cycles, strobes inactive -> STROBE.
  - STROBE:
    - Assert ATA_IORn (DIR = read) or ATA_IOWn (DIR = write) for at least T2 cycles.
    - Final cycle = the cycle in which the strobe count has reached T2 AND synchronised IORDY = 1.
    - If IORDY = 0 at the T2 boundary, stretch. The stretch counter increments each cycle.
    - When the stretch count reaches IORDY_MAX, force the final cycle and pulse ATA_TIMEOUT in that same cycle.
    - ATA_TACK = 1 during exactly the final STROBE cycle; the strobe is still active, so read data is valid. Then -> HOLD.
  - HOLD: exactly 1 cycle, strobes inactive (address/data hold) -> RECOVER.
  - RECOVER: remain until CYC >= T0, then -> IDLE. If the pending flag is set, go instead directly to SETUP with the pending attributes.
- Strobe exclusivity: ATA_IORn and ATA_IOWn are never both 0.
- Strobes: registered outputs, glitch-free.
- Pending start: a start condition seen in HOLD or RECOVER sets pending and latches DIR/mode from that clock. Starts seen in SETUP/STROBE are ignored; the CPU cannot issue them before TACK.
- Simultaneous events:
  - Recovery completion and a new start in the same cycle behave as pending: go to SETUP next.
  - IORDY rising in the same cycle as the stretch count reaching IORDY_MAX: a normal completion; no ATA_TIMEOUT.
- Mode change mid-cycle: PPIO/SPIO changing mid-cycle has no effect until the next start.
- Widths:
  - Strobe and stretch counters are 6 bits.
  - Parameter values must be >= 1. T0 >= T1 + T2 + 1 is required; otherwise RECOVER exits after 1 cycle.

Decomposition:
- Shared U409 package holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, RECOVER)
  - PIO timing constants for PIO0 and PIO4
  - IORDY_MAX
- One sub-module, u409_sync2: the 2-flop IORDY synchroniser, reusable for FLASH_RDY.
- Top-level integration (outside this block):
  - OR ATA_TACK into the transfer-ack merge.
  - Include ATA_SPACE in the PORTSIZE and buffer-enable logic, as now.

Test Plan:
- Primary PIO4 read: PPIO = 1, SEC_SEL = 0, RnW = 1, IORDY = 1, start at edge 0 -> ATA_IORn low edges 2–4, ATA_TACK high at edge 4 only, next start accepted at edge 5 -> SETUP.
- Secondary PIO0 write: SPIO = 0, RnW = 0 -> ATA_IOWn low 7 cycles starting at cycle 4, TACK on the 7th strobe cycle, IDLE reached at CYC = 24; ATA_IORn stays 1 throughout.
- IORDY stretch: PIO4 read, IORDY held low for 10 cycles across the T2 boundary -> strobe extended, TACK 2 sync cycles after IORDY rises, ATA_TIMEOUT = 0.
- IORDY stuck low: PIO0 read -> forced completion after 7 + 50 strobe cycles, ATA_TIMEOUT and ATA_TACK both pulsed once in the same cycle.
- Back-to-back: PIO0, second start asserted during RECOVER at CYC = 12 -> no SETUP before CYC = 24, second cycle begins immediately after with its own latched RnW.
- Reset mid-STROBE: RESETn = 0 on the 3rd strobe cycle -> ATA_IORn = 1 on the next edge, no ATA_TACK, IDLE; a start after reset release is handled normally.
